// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared FSM state, default VGA timing and frame result type
package vga_pkg;

  localparam int H_TOTAL_DFLT      = 800;
  localparam int V_TOTAL_DFLT      = 525;
  localparam int H_START_DFLT      = 48;
  localparam int V_START_DFLT      = 33;
  localparam int SCREEN_H_RES_DFLT = 640;
  localparam int SCREEN_V_RES_DFLT = 480;
  localparam int MASK_X_LO_DFLT    = 316;
  localparam int MASK_X_HI_DFLT    = 324;
  localparam int CNT_W_DFLT        = 12;
  localparam int VGA_RGB_W_DFLT    = 12;

  localparam int X_POS_W   = 10;
  localparam int Y_POS_W   = 9;
  localparam int PIX_CNT_W = X_POS_W + Y_POS_W;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } dec_state_e;

  typedef struct packed {
    logic [X_POS_W-1:0]   min_x;
    logic [X_POS_W-1:0]   max_x;
    logic [Y_POS_W-1:0]   min_y;
    logic [Y_POS_W-1:0]   max_y;
    logic [PIX_CNT_W-1:0] cnt;
    logic                 is_empty;
  } frame_result_t;

endpackage

// File: rtl/vga_bbox_accum.sv
// rtl/vga_bbox_accum.sv - per-frame bounding box and saturating lit-pixel count
module vga_bbox_accum
  import vga_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               hit_i,
  input  logic [X_POS_W-1:0] x_i,
  input  logic [Y_POS_W-1:0] y_i,
  output frame_result_t      res_o
);

  logic [X_POS_W-1:0]   min_x_q, min_x_d, max_x_q, max_x_d;
  logic [Y_POS_W-1:0]   min_y_q, min_y_d, max_y_q, max_y_d;
  logic [PIX_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      min_x_q <= '1;
      max_x_q <= '0;
      min_y_q <= '1;
      max_y_q <= '0;
      cnt_q   <= '0;
    end else begin
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear wins over a coincident hit so that pixel is dropped, not carried over.
  always_comb begin
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      min_x_d = '1;
      max_x_d = '0;
      min_y_d = '1;
      max_y_d = '0;
      cnt_d   = '0;
    end else if (hit_i) begin
      if (x_i < min_x_q) min_x_d = x_i;
      if (x_i > max_x_q) max_x_d = x_i;
      if (y_i < min_y_q) min_y_d = y_i;
      if (y_i > max_y_q) max_y_d = y_i;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    res_o.min_x    = min_x_q;
    res_o.max_x    = max_x_q;
    res_o.min_y    = min_y_q;
    res_o.max_y    = max_y_q;
    res_o.cnt      = cnt_q;
    res_o.is_empty = (cnt_q == '0);
  end

endmodule

// File: rtl/vga_frame_decoder.sv
// rtl/vga_frame_decoder.sv - recovers pixel coordinates from VGA syncs and reports per-frame bbox/count
// Optional sync period checking: VGA_DECODER_TIMING_CHECK_EN
module vga_frame_decoder
  import vga_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_DFLT,
  parameter int V_TOTAL      = V_TOTAL_DFLT,
  parameter int H_START      = H_START_DFLT,
  parameter int V_START      = V_START_DFLT,
  parameter int SCREEN_H_RES = SCREEN_H_RES_DFLT,
  parameter int SCREEN_V_RES = SCREEN_V_RES_DFLT,
  parameter int MASK_X_LO    = MASK_X_LO_DFLT,
  parameter int MASK_X_HI    = MASK_X_HI_DFLT,
  parameter int CNT_W        = CNT_W_DFLT,
  parameter int VGA_RGB_W    = VGA_RGB_W_DFLT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 vga_hs_i,
  input  logic                 vga_vs_i,
  input  logic [VGA_RGB_W-1:0] vga_rgb_i,
  output logic                 lock_o,
  output logic                 frame_valid_o,
  output logic                 empty_o,
  output logic [X_POS_W-1:0]   min_x_o,
  output logic [X_POS_W-1:0]   max_x_o,
  output logic [Y_POS_W-1:0]   min_y_o,
  output logic [Y_POS_W-1:0]   max_y_o,
  output logic [PIX_CNT_W-1:0] pix_cnt_o,
  output logic                 timing_err_o
);

  // The visible window never extends past the sync period.
  localparam int H_VIS_END = (H_START + SCREEN_H_RES < H_TOTAL) ? H_START + SCREEN_H_RES : H_TOTAL;
  localparam int V_VIS_END = (V_START + SCREEN_V_RES < V_TOTAL) ? V_START + SCREEN_V_RES : V_TOTAL;

  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]   H_VIS_LO = CNT_W'(H_START);
  localparam logic [CNT_W-1:0]   H_VIS_HI = CNT_W'(H_VIS_END);
  localparam logic [CNT_W-1:0]   V_VIS_LO = CNT_W'(V_START);
  localparam logic [CNT_W-1:0]   V_VIS_HI = CNT_W'(V_VIS_END);
  localparam logic [X_POS_W-1:0] MASK_LO  = X_POS_W'(MASK_X_LO);
  localparam logic [X_POS_W-1:0] MASK_HI  = X_POS_W'(MASK_X_HI);

  logic                 hs1_q, hs1_d, hs2_q, hs2_d;
  logic                 vs1_q, vs1_d, vs2_q, vs2_d;
  logic [VGA_RGB_W-1:0] rgb1_q, rgb1_d;
  logic [CNT_W-1:0]     hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic                 vs_evt_q, vs_evt_d;
  dec_state_e           state_q, state_d;
  frame_result_t        acc_res, res_q, res_d;
  logic                 fv_q, fv_d, lock_q, lock_d;
  logic                 hs_rise, vs_rise, visible_x, visible_y, masked, hit;
  logic                 publish, acc_clear, tchk_err;
  logic [X_POS_W-1:0]   x_pos;
  logic [Y_POS_W-1:0]   y_pos;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hs1_q    <= 1'b0;
      hs2_q    <= 1'b0;
      vs1_q    <= 1'b0;
      vs2_q    <= 1'b0;
      rgb1_q   <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      vs_evt_q <= 1'b0;
      res_q    <= '0;
      fv_q     <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      hs1_q    <= hs1_d;
      hs2_q    <= hs2_d;
      vs1_q    <= vs1_d;
      vs2_q    <= vs2_d;
      rgb1_q   <= rgb1_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      vs_evt_q <= vs_evt_d;
      res_q    <= res_d;
      fv_q     <= fv_d;
      lock_q   <= lock_d;
    end
  end

  always_comb begin
    hs1_d    = vga_hs_i;
    hs2_d    = hs1_q;
    vs1_d    = vga_vs_i;
    vs2_d    = vs1_q;
    rgb1_d   = vga_rgb_i;
    hs_rise  = hs1_q & ~hs2_q;
    vs_rise  = vs1_q & ~vs2_q;
    // Frame events act one clock after the rise so results land two clocks after sampling.
    vs_evt_d = vs_rise;
  end

  always_comb begin
    hcnt_d = hcnt_q;
    if (hs_rise)              hcnt_d = '0;
    else if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (vs_rise)                           vcnt_d = '0;
    else if (hs_rise && vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 1'b1;
  end

  always_comb begin
    visible_x = (hcnt_q >= H_VIS_LO) && (hcnt_q < H_VIS_HI);
    visible_y = (vcnt_q >= V_VIS_LO) && (vcnt_q < V_VIS_HI);
    x_pos     = X_POS_W'(hcnt_q - H_VIS_LO);
    y_pos     = Y_POS_W'(vcnt_q - V_VIS_LO);
    masked    = (x_pos > MASK_LO) && (x_pos < MASK_HI);
    hit       = visible_x && visible_y && (|rgb1_q) && !masked && !vs_rise;
  end

  vga_bbox_accum u_accum (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (acc_clear),
    .hit_i   (hit),
    .x_i     (x_pos),
    .y_i     (y_pos),
    .res_o   (acc_res)
  );

`ifdef VGA_DECODER_TIMING_CHECK_EN
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W:0]   V_LINES = (CNT_W+1)'(V_TOTAL);

  logic viol_q, viol_d, terr_q, terr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      viol_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      viol_q <= viol_d;
      terr_q <= terr_d;
    end
  end

  // A coincident hsync rise is swallowed by the vcnt clear, so it is added back here.
  always_comb begin
    viol_d = 1'b0;
    if (state_q != IDLE) begin
      if (hs_rise && hcnt_q != H_LAST) viol_d = 1'b1;
      if (vs_rise && ({1'b0, vcnt_q} + {{CNT_W{1'b0}}, hs_rise}) != V_LINES) viol_d = 1'b1;
    end
    terr_d = viol_q;
  end

  assign tchk_err     = viol_q;
  assign timing_err_o = terr_q;
`else
  assign tchk_err     = 1'b0;
  assign timing_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vs_evt_q) state_d = ACQUIRE;
      ACQUIRE: if (vs_evt_q) state_d = LOCKED;
      LOCKED:  state_d = LOCKED;
      default: state_d = IDLE;
    endcase
    if (tchk_err) state_d = IDLE;
  end

  always_comb begin
    publish   = vs_evt_q && !tchk_err && (state_q != IDLE);
    acc_clear = (state_q == IDLE) || vs_evt_q || tchk_err;
  end

  always_comb begin
    res_d  = res_q;
    fv_d   = publish;
    lock_d = lock_q;
    if (publish) begin
      res_d  = acc_res;
      lock_d = 1'b1;
      if (acc_res.is_empty) begin
        res_d.min_x = '0;
        res_d.max_x = '0;
        res_d.min_y = '0;
        res_d.max_y = '0;
      end
    end
    if (tchk_err) lock_d = 1'b0;
  end

  assign lock_o        = lock_q;
  assign frame_valid_o = fv_q;
  assign empty_o       = res_q.is_empty;
  assign min_x_o       = res_q.min_x;
  assign max_x_o       = res_q.max_x;
  assign min_y_o       = res_q.min_y;
  assign max_y_o       = res_q.max_y;
  assign pix_cnt_o     = res_q.cnt;

endmodule

// File: tb/tb_vga_frame_decoder.sv
// tb/tb_vga_frame_decoder.sv - directed scoreboard bench for vga_frame_decoder on a reduced raster
module tb_vga_frame_decoder;

  localparam int HT = 44, VT = 30, HS = 4, VS = 3;
  localparam int HRES = 32, VRES = 24, MLO = 14, MHI = 18;
  // Raw pixel x=0 sits one clock after hcnt==H_START because hcnt lags the sync by the rise detector.
  localparam int PIX_OFS = HS + 1;
`ifdef VGA_DECODER_TIMING_CHECK_EN
  localparam bit TCHK = 1'b1;
`else
  localparam bit TCHK = 1'b0;
`endif

  typedef struct {
    int min_x, max_x, min_y, max_y, cnt;
    bit is_empty;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, hs, vs;
  logic [11:0] rgb;
  logic        lock_o, frame_valid_o, empty_o, timing_err_o;
  logic [9:0]  min_x_o, max_x_o;
  logic [8:0]  min_y_o, max_y_o;
  logic [18:0] pix_cnt_o;

  exp_t exp_q[$];
  exp_t e_none, e_single, e_square, e_black, e_masked, e_edge, e_corner;
  int   checks = 0, failures = 0;
  int   step_n = 0, last_vs_rise = -100, last_hs_rise = -100, err_pulses = 0;

  always #5 clk = ~clk;

  vga_frame_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
    .SCREEN_H_RES(HRES), .SCREEN_V_RES(VRES), .MASK_X_LO(MLO), .MASK_X_HI(MHI),
    .CNT_W(12), .VGA_RGB_W(12)
  ) dut (
    .clk_i(clk), .rst_i(rst), .vga_hs_i(hs), .vga_vs_i(vs), .vga_rgb_i(rgb),
    .lock_o(lock_o), .frame_valid_o(frame_valid_o), .empty_o(empty_o),
    .min_x_o(min_x_o), .max_x_o(max_x_o), .min_y_o(min_y_o), .max_y_o(max_y_o),
    .pix_cnt_o(pix_cnt_o), .timing_err_o(timing_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    if (timing_err_o === 1'b1) begin
      err_pulses++;
      check("terr_latency", step_n - last_hs_rise, 3);
    end
    if (frame_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("fv_latency", step_n - last_vs_rise, 3);
        check("fv_lock", lock_o, 1);
        check("min_x", min_x_o, e.min_x);
        check("max_x", max_x_o, e.max_x);
        check("min_y", min_y_o, e.min_y);
        check("max_y", max_y_o, e.max_y);
        check("pix_cnt", pix_cnt_o, e.cnt);
        check("empty", empty_o, e.is_empty);
      end
    end
  endtask

  task automatic step(input logic h, input logic v, input logic [11:0] c);
    @(negedge clk);
    step_n++;
    observe();
    if (h && !hs) last_hs_rise = step_n;
    if (v && !vs) last_vs_rise = step_n;
    hs  = h;
    vs  = v;
    rgb = c;
  endtask

  function automatic bit lit(input int mode, input int x, input int y);
    case (mode)
      1:       return (x == 10 && y == 12);
      2:       return (x >= 2 && x <= 9 && y >= 3 && y <= 10) || (x >= 29 && x <= 30 && y >= 22 && y <= 23);
      3:       return (y == 5 && x >= 15 && x <= 17);
      4:       return (x == 14 && y == 7) || (x == 18 && y == 8) || (y == 8 && x >= 15 && x <= 17);
      5:       return (x == 0 && y == 0) || (x == 31 && y == 23) || x == -1 || x == 32 || y == -1 || y == 24;
      default: return 1'b0;
    endcase
  endfunction

  // Each frame starts with vsync and hsync rising together; sync pulses sit at the end of line/frame.
  task automatic frame(input int mode, input int nlines, input int short_line, input bit pub, input exp_t e);
    for (int l = 0; l < nlines; l++) begin
      int len = (l == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        logic [11:0] c;
        c = lit(mode, h - PIX_OFS, l - VS) ? (12'h001 << (h % 12)) : 12'h000;
        step(h < len - 4, l < VT - 3, c);
      end
    end
    if (pub) exp_q.push_back(e);
  endtask

  task automatic preroll();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 12'h000);
  endtask

  task automatic check_cleared(input string pfx);
    check({pfx, "_lock"}, lock_o, 0);
    check({pfx, "_fv"}, frame_valid_o, 0);
    check({pfx, "_empty"}, empty_o, 0);
    check({pfx, "_min_x"}, min_x_o, 0);
    check({pfx, "_max_x"}, max_x_o, 0);
    check({pfx, "_min_y"}, min_y_o, 0);
    check({pfx, "_max_y"}, max_y_o, 0);
    check({pfx, "_cnt"}, pix_cnt_o, 0);
    check({pfx, "_terr"}, timing_err_o, 0);
  endtask

  initial begin
    e_none   = '{0, 0, 0, 0, 0, 1'b1};
    e_single = '{10, 10, 12, 12, 1, 1'b0};
    e_square = '{2, 30, 3, 23, 68, 1'b0};
    e_black  = '{0, 0, 0, 0, 0, 1'b1};
    e_masked = '{0, 0, 0, 0, 0, 1'b1};
    e_edge   = '{14, 18, 7, 8, 2, 1'b0};
    e_corner = '{0, 31, 0, 23, 2, 1'b0};

    rst = 1'b1; hs = 1'b0; vs = 1'b0; rgb = 12'h000;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    preroll();

    frame(1, VT, -1, 1'b1, e_single);
    frame(1, VT, -1, 1'b1, e_single);
    frame(2, VT, -1, 1'b1, e_square);
    frame(0, VT, -1, 1'b1, e_black);
    frame(3, VT, -1, 1'b1, e_masked);
    frame(4, VT, -1, 1'b1, e_edge);
    frame(5, VT, -1, 1'b1, e_corner);

    frame(1, VT, 10, !TCHK, e_single);
    check("lock_after_short_line", lock_o, !TCHK);
    frame(2, VT, -1, 1'b1, e_square);

    frame(1, 10, -1, 1'b0, e_none);
    #2;
    rst = 1'b1; hs = 1'b0; vs = 1'b0; rgb = 12'h000;
    #1;
    check_cleared("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    preroll();
    frame(1, VT, -1, 1'b1, e_single);
    check("lock_after_first_rise", lock_o, 0);
    frame(5, VT, -1, 1'b1, e_corner);
    frame(0, 2, -1, 1'b0, e_none);

    check("pending_results", exp_q.size(), 0);
    check("terr_pulses", err_pulses, TCHK ? 1 : 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
